// File: rtl/cpu_io_pkg.sv
// Byte type and width constant shared by the cpu input and output FIFOs.
// Also provides a saturating byte increment used by the drop counter.
package cpu_io_pkg;

    localparam int CPU_BYTE_W = 8;

    typedef logic [CPU_BYTE_W-1:0] byte_t;

    function automatic byte_t sat_inc(input byte_t value);
        return (value == '1) ? value : value + byte_t'(1);
    endfunction

endpackage

// File: rtl/cpu_input_fifo_ram.sv
// Simple dual-port RAM for the cpu input FIFO.
// It has one write port and one read port, and the read port is registered (read-before-write).
module fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it can map onto RAM macros; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignment gives the old contents on a same-address read and write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_input_fifo.sv
// Show-ahead byte FIFO in front of the cpu input port. It holds the pointers, count, flags and head bypass.
// Defining CPU_INPUT_FIFO_DROP_CNT_EN adds a saturating drop_count output.
module cpu_input_fifo
    import cpu_io_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = CPU_BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] data_in,
    output logic              data_available,
    input  logic              data_read,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef CPU_INPUT_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [ADDR_W:0]   count_next;
    logic              push, pop, drop;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] bypass_data;
    logic              bypass_sel;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        push        = 1'b0;
        pop         = 1'b0;
        drop        = 1'b0;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // When the FIFO is full, a pop is always valid, so a concurrent push frees its own slot.
            pop  = data_read && data_available;
            push = wr_en && (!full || data_read);
            drop = wr_en && full && !data_read;
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr_next = wr_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            full           <= 1'b0;
            data_available <= 1'b0;
            overflow       <= 1'b0;
            bypass_sel     <= 1'b0;
            bypass_data    <= '0;
        end else begin
            wr_ptr         <= wr_ptr_next;
            rd_ptr         <= rd_ptr_next;
            count          <= count_next;
            full           <= (count_next == DEPTH_CNT);
            data_available <= (count_next != '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            // The RAM read returns stale data when this edge writes the new head slot, so the written byte is forwarded.
            bypass_sel  <= push && (wr_ptr == rd_ptr_next);
            bypass_data <= wr_data;
        end
    end

    assign data_in = bypass_sel ? bypass_data : ram_rd_data;

`ifdef CPU_INPUT_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop) begin
            drop_count <= ovf_clr ? 8'd1 : sat_inc(drop_count);
        end else if (ovf_clr) begin
            drop_count <= '0;
        end
    end
`endif

endmodule

// File: doc/cpu_input_fifo.md
Name: cpu_input_fifo

Overview:
Show-ahead byte FIFO that sits directly upstream of the cpu core's input port. A UART receiver or host side pushes bytes on wr_en. This block presents the oldest byte on data_in with data_available high, and pops it when the core pulses data_read. It decouples bursty host input from the core's ',' instruction timing and reports dropped bytes.

Parameters:
ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W entries (default 16).
DATA_W, 8, byte width; fixed at 8 for the cpu, parameterised for reuse.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_data  input  DATA_W  byte from the upstream receiver.
wr_en  input  1  single-cycle push strobe for wr_data.
flush  input  1  synchronous clear of contents; does not clear overflow.
ovf_clr  input  1  synchronous clear of the overflow flag.
data_in  output  DATA_W  head byte to cpu; valid while data_available=1.
data_available  output  1  FIFO non-empty.
data_read  input  1  cpu pop strobe; one byte consumed per high cycle.
full  output  1  count == depth.
count  output  ADDR_W+1  current occupancy, 0..depth.
overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0, data_available=0, full=0, overflow=0, data_in=0. Memory contents are not reset.
- Storage: circular buffer, ADDR_W-bit pointers wrapping modulo depth. The extra count bit distinguishes full from empty.
- Push: wr_en=1 and (not full, or data_read=1 while full) -> mem[wr_ptr]<=wr_data, wr_ptr++.
- Pop: data_read=1 and data_available=1 -> rd_ptr++.
- Ignored pop: data_read while empty has no effect on state, with no underflow.
- Show-ahead: data_in is registered and always equals mem[rd_ptr] of the post-edge state. Write-to-data_available latency is exactly 1 cycle from an empty FIFO. The cpu sees the next byte on the cycle after its data_read.
- Simultaneous push and pop:
  - Non-empty, not full: both happen, count unchanged.
  - Full: both accepted, count stays depth, no overflow.
  - Empty: pop ignored, push accepted, count=1.
- Overflow: wr_en=1 and full=1 and no pop -> byte dropped, overflow<=1. The flag holds until ovf_clr or reset. If ovf_clr and a new drop occur in the same cycle, the set wins.
- Flush: pointers and count go to 0 and data_available drops next cycle. Flush has priority over any same-cycle push or pop, which are discarded and do not set overflow.
- Reset mid-transfer: contents are lost and no partial state survives.
- count and full are registered and consistent with data_available every cycle.

Optional Feature:
Macro CPU_INPUT_FIFO_DROP_CNT_EN.
- Defined: adds output drop_count [7:0], a saturating count of dropped bytes. It saturates at 255, is cleared by ovf_clr or reset, and is not cleared by flush. If a drop coincides with ovf_clr, the result is drop_count=1.
- Undefined: the port and counter are absent. The overflow flag alone reports drops.

Decomposition:
- Shared package cpu_io_pkg: byte_t (logic [7:0]) and constant CPU_BYTE_W=8. The cpu output FIFO also uses this package.
- One sub-module, fifo_ram: simple dual-port memory with registered read, parameterised by ADDR_W and DATA_W. The top level holds pointers, count, flags and the show-ahead register.

Test Plan:
- Reset, then push 0x41 once -> next cycle data_available=1, data_in=0x41, count=1. Pulse data_read -> next cycle data_available=0, count=0.
- Push 0x00..0x0F back-to-back (depth 16) -> full=1, count=16, overflow=0. Pop all 16 -> data_in sequence 0x00..0x0F in order, with pointer wrap verified on a second fill of 0x10..0x1F.
- While full, push 0xAA with no read -> overflow=1, 0xAA is never read out, and drop_count=1 when enabled. Pulse ovf_clr -> overflow=0.
- While full, assert wr_en (0x55) and data_read together -> count stays 16, overflow=0, and 0x55 is the last byte drained.
- Pulse data_read while empty for 5 cycles, then push 0x7E -> count=1 and data_in=0x7E (no underflow). Then hold flush with wr_en in the same cycle -> count=0 and overflow=0.
- Assert rst_n=0 mid-way between clock edges with count=7 -> outputs go to reset values immediately without waiting for a clock. Release -> normal push works.
